// File: rtl/wb_arbiter_if.sv
// Bus bundle between the writeback arbiter and its neighbours: pipeline and
// long-latency result inputs, decode issue tracking, and the register-file write port.
interface wb_arbiter_if;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        stall_req;
  logic        wb_write_enable;
  logic [4:0]  wb_write_index;
  logic [31:0] wb_write_data;

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output ll_valid, ll_rd, ll_data,
    output issue_valid, issue_rd,
    input  ll_ready, busy, stall_req,
    input  wb_write_enable, wb_write_index, wb_write_data
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  ll_valid, ll_rd, ll_data,
    input  issue_valid, issue_rd,
    output ll_ready, busy, stall_req,
    output wb_write_enable, wb_write_index, wb_write_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline results take priority, long-latency results queue in a
// FIFO, and a scoreboard tracks destinations with long-latency writes still pending.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]    rdMem   [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [CW-1:0] count;
  logic [SW-1:0] starveCount;
  logic [31:0]   busyReg;
  logic          stallReg;
  logic          wbEnable;
  logic [4:0]    wbIndex;
  logic [31:0]   wbData;

  logic          fifoEmpty;
  logic          fifoFull;
  logic          push;
  logic          pop;
  logic [4:0]    headRd;
  logic [31:0]   headData;
  logic [SW-1:0] starveNext;
  logic [31:0]   busyNext;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == FULL_COUNT);
  assign push      = bus.ll_valid && !fifoFull;
  assign pop       = !bus.pipe_valid && !fifoEmpty;
  assign headRd    = rdMem[headPtr];
  assign headData  = dataMem[headPtr];

  assign bus.ll_ready        = !fifoFull;
  assign bus.busy            = busyReg;
  assign bus.stall_req       = stallReg;
  assign bus.wb_write_enable = wbEnable;
  assign bus.wb_write_index  = wbIndex;
  assign bus.wb_write_data   = wbData;

  // The counter only runs while a queued result is being held off by the pipe;
  // it saturates so stall_req stays asserted for as long as the blockage lasts.
  always_comb begin
    starveNext = '0;
    if (bus.pipe_valid && !fifoEmpty)
      starveNext = (starveCount >= STARVE_MAX) ? starveCount : starveCount + SW'(1);
  end

  // Set is applied after clear so a same-cycle issue to the popped index wins.
  always_comb begin
    busyNext = busyReg;
    if (pop)
      busyNext[headRd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != 5'd0))
      busyNext[bus.issue_rd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rdMem[tailPtr]   <= bus.ll_rd;
      dataMem[tailPtr] <= bus.ll_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr     <= '0;
      tailPtr     <= '0;
      count       <= '0;
      starveCount <= '0;
      stallReg    <= 1'b0;
      busyReg     <= '0;
      wbEnable    <= 1'b0;
      wbIndex     <= '0;
      wbData      <= '0;
    end else begin
      if (push)
        tailPtr <= tailPtr + PW'(1);
      if (pop)
        headPtr <= headPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      starveCount <= starveNext;
      stallReg    <= (starveNext >= STARVE_MAX);
      busyReg     <= busyNext;

      if (bus.pipe_valid) begin
        wbEnable <= (bus.pipe_rd != 5'd0);
        wbIndex  <= bus.pipe_rd;
        wbData   <= bus.pipe_data;
      end else if (pop) begin
        wbEnable <= (headRd != 5'd0);
        wbIndex  <= headRd;
        wbData   <= headData;
      end else begin
        wbEnable <= 1'b0;
      end
    end
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback arbitration stage that sits directly upstream of the register file and drives its single write port (write_enable, write_index, write_data). It merges in-order single-cycle pipeline results with out-of-order long-latency results (load/mul/div), which are buffered in a small FIFO. It also keeps a destination scoreboard, so decode can stall on registers with pending long-latency writes.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of 2, >= 2)
STARVE_LIMIT, 8, consecutive cycles the FIFO head may be blocked by pipe results before stall_req asserts

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
pipe_valid  input  1  single-cycle pipeline result valid; never back-pressured
pipe_rd  input  5  pipeline destination index
pipe_data  input  32  pipeline result
ll_valid  input  1  long-latency result valid
ll_ready  output  1  FIFO can accept; equals !full of current state
ll_rd  input  5  long-latency destination index
ll_data  input  32  long-latency result
issue_valid  input  1  decode issued a long-latency op this cycle
issue_rd  input  5  its destination index
busy  output  32  scoreboard; bit i = write to xi pending
stall_req  output  1  request pipeline bubble so the FIFO can drain
wb_write_enable  output  1  to register file write_enable
wb_write_index  output  5  to register file write_index
wb_write_data  output  32  to register file write_data

Behaviour:
- Reset (synchronous, active-high) clears everything; reset mid-operation discards queued results.
  - FIFO empty; busy=0; stall_req=0; starve counter=0.
  - wb_write_enable=0; wb_write_index=0; wb_write_data=0.
- Enqueue: on posedge with ll_valid && ll_ready, write {ll_rd, ll_data} at the tail.
  - ll_valid while !ll_ready: no enqueue; the producer holds.
  - There is no full-and-pop bypass.
- Selection each cycle:
  - pipe_valid: select the pipe result.
  - Else, FIFO non-empty: select the head and pop it on this posedge.
  - Else: nothing selected.
- Outputs are registered:
  - The selected result appears on wb_* after the next posedge.
  - wb_write_enable = selected && rd != 0.
  - When nothing is selected, wb_write_enable=0 and index/data hold their last values.
- Latency:
  - Pipe result valid in cycle N -> wb_* valid in N+1.
  - Long-latency result enqueued at end of N (FIFO otherwise empty, pipe idle) -> popped at end of N+1 -> wb_* valid in N+2.
- rd=0 results are consumed or popped normally but never write.
- Scoreboard:
  - issue_valid && issue_rd != 0 sets busy[issue_rd].
  - Popping a FIFO entry clears busy[entry rd].
  - Set and clear of the same index on the same posedge: set wins.
  - Issue to an already-busy index leaves it set; decode must not do this.
  - busy[0] is always 0.
  - Pipe results never touch busy.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and pipe_valid=1.
  - Counter clears on any pop or when the FIFO is empty.
  - stall_req is registered; it is 1 when counter >= STARVE_LIMIT, else 0.
  - If pipe_valid is still high while stall_req=1, the pipe still wins (no data loss); stall_req stays high.
- Full boundary:
  - count==DEPTH -> ll_ready=0.
  - Pop while full -> ll_ready=1 in the following cycle.
- Pointers wrap modulo DEPTH; count is tracked in log2(DEPTH)+1 bits.

Test Plan:
- Reset then idle -> wb_write_enable=0, busy=0, ll_ready=1, stall_req=0.
- pipe_valid with rd=5, data=0xDEADBEEF -> next cycle wb_write_enable=1, index=5, data=0xDEADBEEF; with rd=0 -> wb_write_enable=0.
- issue rd=7; 3 cycles later ll_valid rd=7 data=0x12345678, pipe idle:
  - busy[7]=1 from the cycle after issue.
  - wb write 7/0x12345678 two cycles after enqueue.
  - busy[7]=0 after the pop.
- pipe_valid held high, 5 long-latency pushes:
  - ll_ready=0 after 4 accepted; 5th held.
  - stall_req=1 after 8 blocked cycles.
  - Drop pipe_valid: 4 results written in FIFO order, 5th accepted once ll_ready returns, stall_req back to 0.
- Same-cycle issue_rd=9 and pop of an entry for rd=9 -> busy[9] stays 1.
- Reset asserted with 3 queued entries and busy=0x00000280 -> next cycle FIFO empty, busy=0, no further writes.
